// File: rtl/car_link_endpoint.sv
// car_link_endpoint
// Device-side endpoint of the car serial link (8N1, LSB first).
//   RX: decodes the controller's command byte into six command levels and
//       guards them with a link watchdog.
//   TX: periodically serialises the four detector levels as a status byte.
// Ports:
//   sys_clk, rst            clock and synchronous active-high reset
//   rxd / txd               serial command input / status output, idle high
//   front/back/left/right_det  detector levels, sampled at frame launch
//   move_forward .. destroy_barrier  decoded command levels
//   cmd_valid, frame_err    one-cycle pulses per received frame
//   link_alive              high until the watchdog expires
//   tx_busy                 high while a status frame is on txd
module car_link_endpoint #(
  parameter int BAUD_DIV  = 10416,
  parameter int TX_PERIOD = 1_000_000,
  parameter int TIMEOUT   = 5_000_000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  input  logic front_det,
  input  logic back_det,
  input  logic left_det,
  input  logic right_det,
  output logic move_forward,
  output logic move_backward,
  output logic turn_left,
  output logic turn_right,
  output logic place_barrier,
  output logic destroy_barrier,
  output logic cmd_valid,
  output logic frame_err,
  output logic link_alive,
  output logic tx_busy
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(TX_PERIOD);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(TX_PERIOD - 1);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state, rx_next;
  logic            rx_s1, rs, rs_d;
  logic            rs_fall;
  logic [BW-1:0]   rx_cnt;
  logic [2:0]      rx_bits;
  logic [7:0]      rx_byte;
  logic            rx_tick;
  logic            stop_sample, frame_ok, frame_bad;
  logic [TW-1:0]   wd_cnt;

  logic [PW-1:0]   per_cnt;
  logic            per_wrap, tx_pending, tx_launch;
  logic [9:0]      tx_frame;
  logic [BW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;

  // Two-stage synchroniser plus one delay stage for falling-edge detection.
  // Reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rs    <= 1'b1;
      rs_d  <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rs    <= rx_s1;
      rs_d  <= rs;
    end
  end

  assign rs_fall = rs_d & ~rs;

  // RX next-state logic; rx_tick marks the cycle a sample is taken.
  always_comb begin
    rx_next = rx_state;
    rx_tick = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rs_fall) rx_next = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_tick = 1'b1;
          rx_next = rs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_tick = 1'b1;
          if (rx_bits == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_tick = 1'b1;
          rx_next = RX_IDLE;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign stop_sample = (rx_state == RX_STOP) && rx_tick;
  assign frame_ok    = stop_sample && rs && (rx_byte[7:6] == 2'b10);
  assign frame_bad   = stop_sample && !(rs && (rx_byte[7:6] == 2'b10));

  // RX state register, bit timer and LSB-first shift register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bits <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_byte <= {rs, rx_byte[7:1]};
        rx_bits <= rx_bits + 1'b1;
      end
    end
  end

  // Command register and watchdog. A valid frame wins over expiry; the
  // watchdog saturates so an expired link stays cleared until a new frame.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      {destroy_barrier, place_barrier, turn_right,
       turn_left, move_backward, move_forward} <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      link_alive <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      cmd_valid <= frame_ok;
      frame_err <= frame_bad;
      if (frame_ok) begin
        {destroy_barrier, place_barrier, turn_right,
         turn_left, move_backward, move_forward} <= rx_byte[5:0];
        link_alive <= 1'b1;
        wd_cnt     <= '0;
      end else if (wd_cnt == WD_LAST) begin
        {destroy_barrier, place_barrier, turn_right,
         turn_left, move_backward, move_forward} <= '0;
        link_alive <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  assign per_wrap  = (per_cnt == PER_LAST);
  assign tx_launch = !tx_busy && (per_wrap || tx_pending);

  // Status transmitter. tx_frame holds {stop, S, start}; txd always shows
  // bit 0 of the frame and the frame shifts right at each bit boundary.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      per_cnt    <= '0;
      tx_pending <= 1'b0;
      tx_busy    <= 1'b0;
      txd        <= 1'b1;
      tx_frame   <= '1;
      tx_cnt     <= '0;
      tx_bit     <= '0;
    end else begin
      per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;
      if (tx_launch) begin
        tx_busy    <= 1'b1;
        txd        <= 1'b0;
        tx_frame   <= {1'b1, 4'b0000, right_det, left_det, back_det, front_det, 1'b0};
        tx_cnt     <= '0;
        tx_bit     <= '0;
        tx_pending <= 1'b0;
      end else begin
        if (per_wrap && tx_busy) tx_pending <= 1'b1;
        if (tx_busy) begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              tx_busy <= 1'b0;
              txd     <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_frame <= {1'b1, tx_frame[9:1]};
              txd      <= tx_frame[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_car_link_endpoint.sv
// Self-checking bench for car_link_endpoint with short baud/period/timeout.
module tb_car_link_endpoint;

  localparam int B = 16;
  localparam int RX_LAT = 2 + B / 2 + 9 * B + 1;

  logic sys_clk = 1'b0;
  logic rst, rxd;
  logic front_det, back_det, left_det, right_det;
  logic txd, move_forward, move_backward, turn_left, turn_right;
  logic place_barrier, destroy_barrier, cmd_valid, frame_err, link_alive, tx_busy;
  logic [5:0] cmds;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int cv_cnt = 0, cv_cyc = 0, fe_cnt = 0, fe_cyc = 0;
  int rx_start_cyc = 0;
  int cv0, fe0, n;
  logic [9:0] txbits;

  car_link_endpoint #(.BAUD_DIV(B), .TX_PERIOD(400), .TIMEOUT(2000)) dut (
    .sys_clk(sys_clk), .rst(rst), .rxd(rxd), .txd(txd),
    .front_det(front_det), .back_det(back_det), .left_det(left_det), .right_det(right_det),
    .move_forward(move_forward), .move_backward(move_backward),
    .turn_left(turn_left), .turn_right(turn_right),
    .place_barrier(place_barrier), .destroy_barrier(destroy_barrier),
    .cmd_valid(cmd_valid), .frame_err(frame_err),
    .link_alive(link_alive), .tx_busy(tx_busy)
  );

  assign cmds = {destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward};

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse monitor: counts and timestamps cmd_valid / frame_err pulses.
  always @(negedge sys_clk) begin
    if (cmd_valid) begin
      cv_cnt++;
      cv_cyc = cyc;
    end
    if (frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one 8N1 frame on rxd, then a few idle cycles.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(negedge sys_clk);
    rx_start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (B) @(negedge sys_clk);
    end
    rxd = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    {right_det, left_det, back_det, front_det} = 4'b0000;
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_cmds", cmds, 0);
    checkOutput("reset_link_alive", link_alive, 0);
    checkOutput("reset_tx_busy", tx_busy, 0);
    checkOutput("reset_pulses", {cmd_valid, frame_err}, 0);
    rst = 1'b0;
    repeat (4) @(negedge sys_clk);

    // Valid command 0x85: forward + turn left
    cv0 = cv_cnt; fe0 = fe_cnt;
    applyStimulus(8'h85, 1'b1);
    checkOutput("cmd85_cmds", cmds, 6'h05);
    checkOutput("cmd85_valid_count", cv_cnt - cv0, 1);
    checkOutput("cmd85_err_count", fe_cnt - fe0, 0);
    checkOutput("cmd85_latency", cv_cyc - rx_start_cyc, RX_LAT);
    checkOutput("cmd85_link_alive", link_alive, 1);

    // Bad header 0x45
    cv0 = cv_cnt; fe0 = fe_cnt;
    applyStimulus(8'h45, 1'b1);
    checkOutput("hdr45_err_count", fe_cnt - fe0, 1);
    checkOutput("hdr45_valid_count", cv_cnt - cv0, 0);
    checkOutput("hdr45_latency", fe_cyc - rx_start_cyc, RX_LAT);
    checkOutput("hdr45_cmds", cmds, 6'h05);

    // Bad stop bit on 0x81
    cv0 = cv_cnt; fe0 = fe_cnt;
    applyStimulus(8'h81, 1'b0);
    checkOutput("stop0_err_count", fe_cnt - fe0, 1);
    checkOutput("stop0_valid_count", cv_cnt - cv0, 0);
    checkOutput("stop0_cmds", cmds, 6'h05);

    // Status frame with {right,left,back,front} = 1010
    {right_det, left_det, back_det, front_det} = 4'b1010;
    n = 0;
    while (tx_busy && n < 400) begin @(negedge sys_clk); n++; end
    n = 0;
    while (!tx_busy && n < 1000) begin @(negedge sys_clk); n++; end
    checkOutput("tx_launch", tx_busy, 1);
    txbits = '1;
    n = 0;
    while (tx_busy && n < 400) begin
      if (n % 16 == 8 && n / 16 < 10) txbits[n / 16] = txd;
      n++;
      @(negedge sys_clk);
    end
    checkOutput("tx_start_bit", txbits[0], 0);
    checkOutput("tx_data", txbits[8:1], 8'h0A);
    checkOutput("tx_stop_bit", txbits[9], 1);
    checkOutput("tx_busy_cycles", n, 160);
    checkOutput("tx_idle_after", txd, 1);

    // All commands, then let the watchdog expire
    cv0 = cv_cnt;
    applyStimulus(8'hBF, 1'b1);
    checkOutput("cmdBF_valid_count", cv_cnt - cv0, 1);
    checkOutput("cmdBF_cmds", cmds, 6'h3F);
    n = 0;
    while (cyc != cv_cyc + 1999 && n < 3000) begin @(negedge sys_clk); n++; end
    checkOutput("wd_wait", n < 3000, 1);
    checkOutput("wd_before_cmds", cmds, 6'h3F);
    checkOutput("wd_before_link", link_alive, 1);
    @(negedge sys_clk);
    checkOutput("wd_expired_cmds", cmds, 0);
    checkOutput("wd_expired_link", link_alive, 0);

    // Short low glitch, then a real frame
    cv0 = cv_cnt; fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge sys_clk);
    rxd = 1'b1;
    repeat (20) @(negedge sys_clk);
    checkOutput("glitch_valid_count", cv_cnt - cv0, 0);
    checkOutput("glitch_err_count", fe_cnt - fe0, 0);
    applyStimulus(8'h82, 1'b1);
    checkOutput("cmd82_cmds", cmds, 6'h02);
    checkOutput("cmd82_valid_count", cv_cnt - cv0, 1);

    // Reset in the middle of both a TX and an RX frame
    n = 0;
    while (!tx_busy && n < 1000) begin @(negedge sys_clk); n++; end
    checkOutput("mid_tx_busy", tx_busy, 1);
    rxd = 1'b0;
    repeat (40) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    checkOutput("midrst_txd", txd, 1);
    checkOutput("midrst_tx_busy", tx_busy, 0);
    checkOutput("midrst_cmds", cmds, 0);
    checkOutput("midrst_link", link_alive, 0);
    checkOutput("midrst_pulses", {cmd_valid, frame_err}, 0);
    rxd = 1'b1;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    cv0 = cv_cnt;
    applyStimulus(8'hA3, 1'b1);
    checkOutput("postrst_cmds", cmds, 6'h23);
    checkOutput("postrst_valid_count", cv_cnt - cv0, 1);
    checkOutput("postrst_link", link_alive, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/car_link_endpoint.md
# car_link_endpoint

Device-side endpoint of the car serial link. It receives the 8N1 command byte that the car controller transmits, validates and decodes it into per-command levels, and guards them with a link watchdog. In the other direction it periodically serialises the four detector inputs into the status byte the controller expects. It sits in the simulated-device testbench/FPGA partner, opposite the controller's UART.

## Interface
- BAUD_DIV, 10416: sys_clk cycles per bit (100 MHz / 9600); must be ≥ 4 and even.
- TX_PERIOD, 1_000_000: cycles between status-frame launches.
- TIMEOUT, 5_000_000: cycles without a valid command frame before commands are cleared.
- sys_clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  serial command line from the controller, idle high.
- txd  out  1  serial status line to the controller, idle high.
- front_det, back_det, left_det, right_det  in  1 each  detector levels.
- move_forward, move_backward, turn_left, turn_right, place_barrier, destroy_barrier  out  1 each  decoded command levels.
- cmd_valid  out  1  one-cycle pulse when a valid frame updates the commands.
- frame_err  out  1  one-cycle pulse on a bad stop bit or a bad header.
- link_alive  out  1  high while the watchdog has not expired.
- tx_busy  out  1  high while a status frame is being shifted out.

## Operation
- Reset: txd=1; all command outputs, cmd_valid, frame_err, link_alive and tx_busy = 0; all counters and state cleared.
- rxd passes through a 2-FF synchroniser. All RX decisions use the synchronised signal rs.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a falling edge of rs.
  - START: wait BAUD_DIV/2 cycles, then sample. If rs=1 (glitch), return to IDLE. Otherwise go to DATA.
  - DATA: sample every BAUD_DIV cycles, 8 bits, LSB first.
  - STOP: sample after a further BAUD_DIV cycles, then return to IDLE.
- Frame check on the stop sample, with byte b:
  - If stop=1 and b[7:6]=2'b10: load {destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward} ← b[5:0], pulse cmd_valid, set link_alive=1, and clear the watchdog.
  - Otherwise pulse frame_err and leave the commands unchanged.
- If b[1:0]=2'b11 (forward and backward both set) on a valid frame: load both as given. No arbitration is done in this block.
- Watchdog: a counter increments every cycle and is cleared by cmd_valid. When it reaches TIMEOUT-1, all six commands and link_alive clear on the next cycle. The counter saturates and does not wrap.
- TX: a period counter counts 0..TX_PERIOD-1 and wraps.
  - At wrap with TX idle: capture S = {4'b0000, right_det, left_det, back_det, front_det} and launch a frame.
  - At wrap with TX busy: set a pending flag. The frame launches on the first idle cycle after the current one, with detectors captured at launch.
  - Only one pending launch is held; further wraps while pending are dropped.
- TX frame: start bit 0, S[0]..S[7], stop bit 1. Each bit lasts BAUD_DIV cycles. tx_busy is high from the first start-bit cycle through the last stop-bit cycle.
- A reset asserted mid-frame (RX or TX) aborts the frame immediately: txd=1 on the next edge and the RX FSM returns to IDLE.

## Timing
- RX latency: cmd_valid and the new command levels appear 1 cycle after the stop sample. The stop sample is taken 2 + BAUD_DIV/2 + 9·BAUD_DIV cycles after the rxd falling edge.
- frame_err follows the same timing as cmd_valid.
- TX: txd falls on the cycle after the launch decision. A frame lasts exactly 10·BAUD_DIV cycles. tx_busy falls on the cycle txd would start the next idle bit.
- Back-to-back RX frames are accepted with zero idle bits: a falling edge is detectable immediately after the stop sample.
- RX and TX run fully independently. Simultaneous events in both directions need no ordering.

## Test plan
- Bench uses BAUD_DIV=16, TX_PERIOD=400, TIMEOUT=2000. Send byte 0x85 → 1 cycle after the stop sample: move_forward=1, turn_left=1, all other commands 0, cmd_valid pulses once, link_alive=1.
- Send 0x45 (header 01) → frame_err pulses, commands unchanged. Send 0x81 with stop bit forced to 0 → frame_err pulses, commands unchanged.
- Hold detectors {right,left,back,front}=4'b1010, let the period wrap → txd carries start 0, bits 0,1,0,1,0,0,0,0, stop 1, each bit 16 cycles; decoded value 0x0A; tx_busy high for 160 cycles.
- Send 0xBF, then stay silent → all commands high; exactly 2000 cycles after cmd_valid, commands = 0 and link_alive = 0.
- Drive a 4-cycle low glitch on rxd → no cmd_valid, no frame_err, RX back in IDLE. Then send 0x82 immediately → move_backward=1.
- Assert rst mid-TX and mid-RX frame → next cycle txd=1 and all outputs 0. A fresh frame after rst is decoded correctly.
